// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and helpers for the bit-serial adder.
//   - sa_state_t : controller states (idle / shifting / result held)
//   - cnt_width  : width of the bit counter for a given operand width
//   Optional feature macro used by the adder: SERIAL_ADDER_OVF_EN
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } sa_state_t;

   // The bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
   // A floor of one bit keeps the declaration legal for tiny widths.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// serial_adder_full_adder
//   Single-bit full adder cell used by the serial adder; purely combinational.
//   Ports:
//     a, b  in  1  addend bits
//     cin   in  1  carry in
//     s     out 1  sum bit
//     cout  out 1  carry out
// -----------------------------------------------------------------------------
module serial_adder_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   // Classic majority / parity formulation of one adder bit.
   always_comb begin
      s    = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are accepted over a valid/ready
//   handshake, added LSB-first one bit per clock through one full-adder cell
//   and a carry flop, and the result is offered over a second handshake.
//   Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow
//   output ovf.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      synchronous active-low reset
//     in_valid   in   1      operands valid
//     in_ready   out  1      adder idle and able to accept operands
//     a, b       in   WIDTH  unsigned operands
//     cin        in   1      carry in
//     out_valid  out  1      sum/cout (and ovf) valid
//     out_ready  in   1      consumer takes the result
//     sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//     cout       out  1      carry out of the MSB
//     ovf        out  1      signed overflow (SERIAL_ADDER_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int             CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   sa_state_t        state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic             fa_s;
   logic             fa_c;

   serial_adder_full_adder u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_c)
   );

   // Next-state logic for the controller and datapath. Handshake outputs are
   // computed here and registered, so in_ready/out_valid change only on edges;
   // in particular in_ready stays low in DONE, so an operand presented during
   // the output handshake is only taken the cycle after returning to IDLE.
   always_comb begin
      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      cout_d      = cout_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d       = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               a_sh_d     = a;
               b_sh_d     = b;
               carry_d    = cin;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = ST_SHIFT;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d      = 1'b0;
`endif
            end
         end
         ST_SHIFT: begin
            // Sum bits enter at the top and walk down, so after WIDTH shifts
            // bit 0 of the result sits at sum[0].
            carry_d = fa_c;
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            sum_d   = {fa_s, sum_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               cout_d      = fa_c;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q is the carry into the MSB stage on this last edge.
               ovf_d       = fa_c ^ carry_q;
`endif
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset; a reset in any state
   // abandons the operation in flight and returns to an accepting IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder: an 8-bit instance exercised with
//   directed and random operations against an arithmetic reference, plus a
//   2-bit instance checked over every operand combination.
//   Honours SERIAL_ADDER_OVF_EN for the ovf port.
// -----------------------------------------------------------------------------
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rstN;
   logic         inValid, inReady, cin, outValid, outReady, cout;
   logic [W-1:0] a, b, sum;
   logic         inValid2, inReady2, cin2, outValid2, outReady2, cout2;
   logic [1:0]   a2, b2, sum2;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf, ovf2;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
      .a(a), .b(b), .cin(cin), .out_valid(outValid), .out_ready(outReady),
      .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf)
`endif
   );

   serial_adder #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rstN), .in_valid(inValid2), .in_ready(inReady2),
      .a(a2), .b(b2), .cin(cin2), .out_valid(outValid2), .out_ready(outReady2),
      .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf2)
`endif
   );

   // Reference: the full unsigned sum including the carry bit.
   function automatic logic [W:0] refSum(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
      int r;
      r = int'(x) + int'(y) + (c ? 1 : 0);
      return (W+1)'(r);
   endfunction

   // Reference: two's-complement overflow from signed integer arithmetic.
   function automatic logic refOvf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
      int sx, sy, r;
      sx = (int'(x) >= 128) ? int'(x) - 256 : int'(x);
      sy = (int'(y) >= 128) ? int'(y) - 256 : int'(y);
      r  = sx + sy + (c ? 1 : 0);
      return (r > 127) || (r < -128);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands and return one step after the accept edge.
   task automatic applyStimulus(input logic [W-1:0] opA, input logic [W-1:0] opB,
                                input logic opCin, input bit keepValid);
      int waited = 0;
      a = opA;
      b = opB;
      cin = opCin;
      inValid = 1'b1;
      while (!inReady && waited < 50) begin
         tick();
         waited++;
      end
      checkOutput("acceptReady", {31'b0, inReady}, 32'd1);
      tick();
      if (!keepValid) inValid = 1'b0;
   endtask

   // Wait for out_valid (bounded), then compare latency and result.
   task automatic waitResult(input string tag, input logic [W-1:0] opA,
                             input logic [W-1:0] opB, input logic opCin);
      int cycles = 0;
      logic [W:0] exp;
      exp = refSum(opA, opB, opCin);
      while (!outValid && cycles < 50) begin
         tick();
         cycles++;
      end
      checkOutput({tag, "_latency"}, 32'(cycles), 32'(W));
      checkOutput({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
      checkOutput({tag, "_cout"}, {31'b0, cout}, {31'b0, exp[W]});
`ifdef SERIAL_ADDER_OVF_EN
      checkOutput({tag, "_ovf"}, {31'b0, ovf}, {31'b0, refOvf(opA, opB, opCin)});
`endif
   endtask

   // Hold back-pressure for a while, then take the result.
   task automatic drainResult(input string tag, input int holdCycles);
      outReady = 1'b0;
      for (int i = 0; i < holdCycles; i++) tick();
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      checkOutput({tag, "_validDrop"}, {31'b0, outValid}, 32'd0);
      checkOutput({tag, "_readyBack"}, {31'b0, inReady}, 32'd1);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   held;
      rstN = 1'b0;
      inValid = 1'b0; outReady = 1'b0; a = '0; b = '0; cin = 1'b0;
      inValid2 = 1'b0; outReady2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
      tick();
      tick();

      // Reset state
      checkOutput("rst_inReady", {31'b0, inReady}, 32'd1);
      checkOutput("rst_outValid", {31'b0, outValid}, 32'd0);
      checkOutput("rst_sum", 32'(sum), 32'd0);
      checkOutput("rst_cout", {31'b0, cout}, 32'd0);
      rstN = 1'b1;
      tick();

      // Basic add
      applyStimulus(8'd100, 8'd55, 1'b0, 1'b0);
      waitResult("basic", 8'd100, 8'd55, 1'b0);
      drainResult("basic", 0);

      // Wrap to zero with carry out
      applyStimulus(8'd255, 8'd0, 1'b1, 1'b0);
      waitResult("wrap", 8'd255, 8'd0, 1'b1);
      drainResult("wrap", 0);

      // Signed overflow boundary
      applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0);
      waitResult("ovf", 8'h7F, 8'h01, 1'b0);
      drainResult("ovf", 1);

      // Back-pressure: result and handshake outputs frozen while held
      applyStimulus(8'h5A, 8'h3C, 1'b1, 1'b0);
      waitResult("bp", 8'h5A, 8'h3C, 1'b1);
      held = refSum(8'h5A, 8'h3C, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bp_outValid", {31'b0, outValid}, 32'd1);
         checkOutput("bp_sum", 32'(sum), 32'(held[W-1:0]));
         checkOutput("bp_cout", {31'b0, cout}, {31'b0, held[W]});
         checkOutput("bp_inReady", {31'b0, inReady}, 32'd0);
      end
      drainResult("bp", 0);

      // in_valid held with new operands during SHIFT is ignored
      applyStimulus(8'd20, 8'd30, 1'b0, 1'b1);
      a = 8'hAA;
      b = 8'h77;
      cin = 1'b1;
      waitResult("noOverlap", 8'd20, 8'd30, 1'b0);
      // Handshake edge with in_valid high: not accepted on that edge
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      checkOutput("hsEdge_outValid", {31'b0, outValid}, 32'd0);
      checkOutput("hsEdge_inReady", {31'b0, inReady}, 32'd1);
      tick();
      checkOutput("nextAccept_inReady", {31'b0, inReady}, 32'd0);
      inValid = 1'b0;
      waitResult("secondOp", 8'hAA, 8'h77, 1'b1);
      drainResult("secondOp", 0);

      // Reset on the third SHIFT cycle aborts the operation
      applyStimulus(8'd9, 8'd9, 1'b0, 1'b0);
      tick();
      tick();
      rstN = 1'b0;
      tick();
      checkOutput("abort_outValid", {31'b0, outValid}, 32'd0);
      checkOutput("abort_sum", 32'(sum), 32'd0);
      checkOutput("abort_cout", {31'b0, cout}, 32'd0);
      checkOutput("abort_inReady", {31'b0, inReady}, 32'd1);
      rstN = 1'b1;
      applyStimulus(8'd3, 8'd4, 1'b0, 1'b0);
      waitResult("afterAbort", 8'd3, 8'd4, 1'b0);
      drainResult("afterAbort", 0);

      // Random operations with random back-pressure
      for (int n = 0; n < 25; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         applyStimulus(ra, rb, rc, 1'b0);
         waitResult($sformatf("rand%0d", n), ra, rb, rc);
         drainResult($sformatf("rand%0d", n), int'($urandom_range(0, 3)));
      end

      // Two-bit instance, every combination
      for (int ia = 0; ia < 4; ia++) begin
         for (int ib = 0; ib < 4; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               int waited = 0;
               a2 = 2'(ia);
               b2 = 2'(ib);
               cin2 = 1'(ic);
               inValid2 = 1'b1;
               while (!inReady2 && waited < 50) begin
                  tick();
                  waited++;
               end
               tick();
               inValid2 = 1'b0;
               waited = 0;
               while (!outValid2 && waited < 50) begin
                  tick();
                  waited++;
               end
               checkOutput($sformatf("w2_%0d_%0d_%0d", ia, ib, ic),
                           {29'b0, cout2, sum2}, 32'(ia + ib + ic));
               outReady2 = 1'b1;
               tick();
               outReady2 = 1'b0;
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
